// File: rtl/uart_rx_cmd_parser_pkg.sv
// ============================================================================
// Module : uart_rx_cmd_parser_pkg
// Brief  : Opcodes, operand register addresses and FSM encoding shared by the
//          UART command parser and its testbench-facing top.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_rx_cmd_parser_pkg;

   localparam logic [7:0] OPC_RF_WR   = 8'hAA;
   localparam logic [7:0] OPC_RF_RD   = 8'hBB;
   localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
   localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

   localparam int unsigned OPA_ADDR = 0;
   localparam int unsigned OPB_ADDR = 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_ADDR = 3'd1,
      ST_WR_DATA = 3'd2,
      ST_RD_ADDR = 3'd3,
      ST_OP_A    = 3'd4,
      ST_OP_B    = 3'd5,
      ST_OP_FUN  = 3'd6,
      ST_NOP_FUN = 3'd7
   } state_e;

endpackage

`default_nettype wire

// File: rtl/uart_frame_timer.sv
// ============================================================================
// Module : uart_frame_timer
// Brief  : Inter-byte gap counter that flags a stalled command frame.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_frame_timer #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   // The byte cycle is the first of the TIMEOUT_CYCLES, so expiry is flagged
   // one count early; the registered CMD_ERR then lands exactly on time.
   localparam logic [CW-1:0] EXPIRE_AT = CW'(TIMEOUT_CYCLES - 2);

   logic [CW-1:0] cnt_q;

   assign expire_o = en_i && !clr_i && (cnt_q == EXPIRE_AT);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i || expire_o) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_rx_cmd_parser.sv
// ============================================================================
// Module : uart_rx_cmd_parser
// Brief  : Decodes UART byte frames into register-file and ALU strobes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_cmd_parser
   import uart_rx_cmd_parser_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int FUN_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] rx_p_data_i,
   input  logic                  rx_d_vld_i,
   input  logic                  par_err_i,
   input  logic                  frm_err_i,
   output logic                  rf_wr_en_o,
   output logic                  rf_rd_en_o,
   output logic [ADDR_WIDTH-1:0] rf_addr_o,
   output logic [DATA_WIDTH-1:0] rf_wr_data_o,
   output logic                  alu_en_o,
   output logic [FUN_WIDTH-1:0]  alu_fun_o,
   output logic                  cmd_err_o
);

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [ADDR_WIDTH-1:0] rf_addr_q;
   logic [DATA_WIDTH-1:0] rf_wr_data_q;
   logic [FUN_WIDTH-1:0]  alu_fun_q;
   logic                  rf_wr_en_q;
   logic                  rf_rd_en_q;
   logic                  alu_en_q;
   logic                  cmd_err_q;
   logic                  byte_err;
   logic                  tmr_expire;

   assign byte_err = par_err_i | frm_err_i;

   uart_frame_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (rx_d_vld_i),
      .en_i     (state_q != ST_IDLE),
      .expire_o (tmr_expire)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         wr_addr_q    <= '0;
         rf_addr_q    <= '0;
         rf_wr_data_q <= '0;
         alu_fun_q    <= '0;
         rf_wr_en_q   <= 1'b0;
         rf_rd_en_q   <= 1'b0;
         alu_en_q     <= 1'b0;
         cmd_err_q    <= 1'b0;
      end else begin
         rf_wr_en_q <= 1'b0;
         rf_rd_en_q <= 1'b0;
         alu_en_q   <= 1'b0;
         cmd_err_q  <= 1'b0;
         if (rx_d_vld_i) begin
            if (byte_err) begin
               cmd_err_q <= 1'b1;
               state_q   <= ST_IDLE;
            end else begin
               case (state_q)
                  ST_IDLE: begin
                     if (rx_p_data_i == DATA_WIDTH'(OPC_RF_WR))        state_q <= ST_WR_ADDR;
                     else if (rx_p_data_i == DATA_WIDTH'(OPC_RF_RD))   state_q <= ST_RD_ADDR;
                     else if (rx_p_data_i == DATA_WIDTH'(OPC_ALU_OP))  state_q <= ST_OP_A;
                     else if (rx_p_data_i == DATA_WIDTH'(OPC_ALU_NOP)) state_q <= ST_NOP_FUN;
                     else                                              cmd_err_q <= 1'b1;
                  end
                  ST_WR_ADDR: begin
                     wr_addr_q <= rx_p_data_i[ADDR_WIDTH-1:0];
                     state_q   <= ST_WR_DATA;
                  end
                  ST_WR_DATA: begin
                     rf_addr_q    <= wr_addr_q;
                     rf_wr_data_q <= rx_p_data_i;
                     rf_wr_en_q   <= 1'b1;
                     state_q      <= ST_IDLE;
                  end
                  ST_RD_ADDR: begin
                     rf_addr_q  <= rx_p_data_i[ADDR_WIDTH-1:0];
                     rf_rd_en_q <= 1'b1;
                     state_q    <= ST_IDLE;
                  end
                  ST_OP_A: begin
                     rf_addr_q    <= ADDR_WIDTH'(OPA_ADDR);
                     rf_wr_data_q <= rx_p_data_i;
                     rf_wr_en_q   <= 1'b1;
                     state_q      <= ST_OP_B;
                  end
                  ST_OP_B: begin
                     rf_addr_q    <= ADDR_WIDTH'(OPB_ADDR);
                     rf_wr_data_q <= rx_p_data_i;
                     rf_wr_en_q   <= 1'b1;
                     state_q      <= ST_OP_FUN;
                  end
                  ST_OP_FUN, ST_NOP_FUN: begin
                     alu_fun_q <= rx_p_data_i[FUN_WIDTH-1:0];
                     alu_en_q  <= 1'b1;
                     state_q   <= ST_IDLE;
                  end
                  default: state_q <= ST_IDLE;
               endcase
            end
         end else if (tmr_expire) begin
            cmd_err_q <= 1'b1;
            state_q   <= ST_IDLE;
         end
      end
   end

   assign rf_wr_en_o   = rf_wr_en_q;
   assign rf_rd_en_o   = rf_rd_en_q;
   assign rf_addr_o    = rf_addr_q;
   assign rf_wr_data_o = rf_wr_data_q;
   assign alu_en_o     = alu_en_q;
   assign alu_fun_o    = alu_fun_q;
   assign cmd_err_o    = cmd_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cmd_parser.sv
// ============================================================================
// Module : tb_uart_rx_cmd_parser
// Brief  : Directed and random frames checked every cycle against a frame model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_cmd_parser;

   localparam int TMO = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_vld = 1'b0;
   logic       par = 1'b0;
   logic       frm = 1'b0;
   logic       wr_en, rd_en, alu_en, cmd_err;
   logic [3:0] addr, fun;
   logic [7:0] wdata;

   int n_pass = 0;
   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   // reference model state: bytes of the frame in progress, gap since last byte
   logic [7:0] frame[$];
   int         gap = 0;
   logic       e_wr = 0, e_rd = 0, e_alu = 0, e_err = 0;
   logic [3:0] e_addr = 0, e_fun = 0;
   logic [7:0] e_data = 0;

   always #5 clk = ~clk;

   uart_rx_cmd_parser #(
      .DATA_WIDTH     (8),
      .ADDR_WIDTH     (4),
      .FUN_WIDTH      (4),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .rx_p_data_i  (rx_data),
      .rx_d_vld_i   (rx_vld),
      .par_err_i    (par),
      .frm_err_i    (frm),
      .rf_wr_en_o   (wr_en),
      .rf_rd_en_o   (rd_en),
      .rf_addr_o    (addr),
      .rf_wr_data_o (wdata),
      .alu_en_o     (alu_en),
      .alu_fun_o    (fun),
      .cmd_err_o    (cmd_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("rf_wr_en", 32'(wr_en), 32'(e_wr));
      chk("rf_rd_en", 32'(rd_en), 32'(e_rd));
      chk("alu_en", 32'(alu_en), 32'(e_alu));
      chk("cmd_err", 32'(cmd_err), 32'(e_err));
      chk("rf_addr", 32'(addr), 32'(e_addr));
      chk("rf_wr_data", 32'(wdata), 32'(e_data));
      chk("alu_fun", 32'(fun), 32'(e_fun));
   endtask

   function automatic int frame_len(input logic [7:0] op);
      case (op)
         8'hAA:   return 3;
         8'hBB:   return 2;
         8'hCC:   return 4;
         8'hDD:   return 2;
         default: return 0;
      endcase
   endfunction

   // Expected outputs for the cycle after the given inputs.
   task automatic model_step(input logic v, input logic [7:0] d, input logic p, input logic f);
      int         need;
      logic [7:0] op, a;
      e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0;
      if (v) begin
         gap = 0;
         if (p || f) begin
            e_err = 1;
            frame.delete();
         end else begin
            frame.push_back(d);
            op = frame[0];
            need = frame_len(op);
            if (need == 0) begin
               e_err = 1;
               frame.delete();
            end else begin
               if (op == 8'hAA && frame.size() == 3) begin
                  a = frame[1];
                  e_wr = 1; e_addr = a[3:0]; e_data = d;
               end
               if (op == 8'hBB && frame.size() == 2) begin
                  e_rd = 1; e_addr = d[3:0];
               end
               if (op == 8'hCC && frame.size() == 2) begin
                  e_wr = 1; e_addr = 4'd0; e_data = d;
               end
               if (op == 8'hCC && frame.size() == 3) begin
                  e_wr = 1; e_addr = 4'd1; e_data = d;
               end
               if ((op == 8'hCC && frame.size() == 4) || (op == 8'hDD && frame.size() == 2)) begin
                  e_alu = 1; e_fun = d[3:0];
               end
               if (frame.size() == need) frame.delete();
            end
         end
      end else if (frame.size() != 0) begin
         gap++;
         // abandoned frame is reported TMO cycles after its last byte
         if (gap + 1 == TMO) begin
            e_err = 1;
            frame.delete();
         end
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic p, input logic f);
      @(negedge clk);
      rx_vld = v;
      rx_data = v ? d : 8'($urandom);
      par = v ? p : 1'($urandom);
      frm = v ? f : 1'($urandom);
      model_step(v, d, p, f);
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
   endtask

   task automatic send(input logic [7:0] d, input logic p, input logic f, input int idle);
      step(1'b1, d, p, f);
      for (int i = 0; i < idle; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      rx_vld = 1'b0;
      frame.delete();
      gap = 0;
      e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0;
      e_addr = 0; e_data = 0; e_fun = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         check_outputs();
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] b;
      int         len, idle;
      logic       pe, fe;

      do_reset(3);

      // AA,05,3C with 16-cycle spacing
      send(8'hAA, 0, 0, 15); send(8'h05, 0, 0, 15); send(8'h3C, 0, 0, 4);
      // BB,17: address truncated to 7
      send(8'hBB, 0, 0, 2); send(8'h17, 0, 0, 3);
      // CC,12,34,02 then DD,03
      send(8'hCC, 0, 0, 1); send(8'h12, 0, 0, 1); send(8'h34, 0, 0, 1); send(8'h02, 0, 0, 2);
      send(8'hDD, 0, 0, 1); send(8'h03, 0, 0, 2);
      // errored data byte: parity, then framing; then junk opcode
      send(8'hAA, 0, 0, 1); send(8'h05, 0, 0, 1); send(8'h3C, 1, 0, 2);
      send(8'hAA, 0, 0, 1); send(8'h05, 0, 0, 1); send(8'h3C, 0, 1, 2);
      send(8'h55, 0, 0, 2);
      send(8'hAA, 1, 0, 1); send(8'h05, 0, 0, 2);
      // timeout, recovery, and a byte landing on the expiry cycle
      send(8'hAA, 0, 0, TMO + 3);
      send(8'hAA, 0, 0, 1); send(8'h01, 0, 0, 1); send(8'hFF, 0, 0, 2);
      send(8'hAA, 0, 0, TMO - 2); send(8'h09, 0, 0, 2); send(8'h77, 0, 0, 2);
      send(8'hAA, 0, 0, TMO - 1); send(8'h09, 0, 0, 3);
      // reset in the middle of a CC frame, then a full AA frame
      send(8'hCC, 0, 0, 1); send(8'h12, 0, 0, 1);
      do_reset(3);
      send(8'hAA, 0, 0, 1); send(8'h0A, 0, 0, 1); send(8'h5A, 0, 0, 3);

      // random frames, occasional corrupted bytes and long stalls
      for (int fr = 0; fr < 200; fr++) begin
         case ($urandom_range(0, 4))
            0: b = 8'hAA;
            1: b = 8'hBB;
            2: b = 8'hCC;
            3: b = 8'hDD;
            default: b = 8'($urandom);
         endcase
         len = frame_len(b);
         if (len == 0) len = 1;
         for (int i = 0; i < len; i++) begin
            pe = ($urandom_range(0, 29) == 0);
            fe = ($urandom_range(0, 29) == 0);
            idle = ($urandom_range(0, 14) == 0) ? int'($urandom_range(TMO - 3, TMO + 3))
                                                 : int'($urandom_range(0, 3));
            send((i == 0) ? b : 8'($urandom), pe, fe, idle);
         end
      end
      send(8'hDD, 0, 0, 0); send(8'h0F, 0, 0, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
